// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide execute unit
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_i / ready_o   request handshake (ready_o high only in IDLE)
//   func3_i             RV32M operation select
//   reg1_i, reg2_i      rs1 / rs2 operands
//   wd_i, wreg_i        destination register and write-enable to carry along
//   flush_i             cancel any in-flight or unconsumed operation
//   valid_o / ready_i   result handshake
//   wdata_o, wd_o,      result, destination, write-enable (all zero while
//   wreg_o              valid_o is low)
//   busy_o              unit not idle; feeds the pipeline stall request
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int BPC     = 1,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [2:0]         func3_i,
  input  logic [XLEN-1:0]    reg1_i,
  input  logic [XLEN-1:0]    reg2_i,
  input  logic [REGADDR-1:0] wd_i,
  input  logic               wreg_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    wdata_o,
  output logic [REGADDR-1:0] wd_o,
  output logic               wreg_o,
  output logic               busy_o
);

  localparam int N  = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;
  logic   accept;

  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic [REGADDR-1:0] wd_r;
  logic               wreg_r;
  logic               neg_a;     // sign of product / quotient
  logic               neg_r;     // sign of remainder
  logic               spec;      // special case, result preloaded in res
  logic [XLEN-1:0]    res;
  logic [XLEN-1:0]    x;         // multiplier (shifts right) or dividend/quotient
  logic [XLEN-1:0]    y;         // divisor magnitude
  logic [XLEN-1:0]    rem;       // partial remainder
  logic [2*XLEN-1:0]  mc;        // multiplicand, shifted left BPC per cycle
  logic [2*XLEN-1:0]  acc;       // product accumulator

  // ---------------- request decode ----------------
  logic            is_div, sgn1, sgn2, s1, s2, div0, ovf, special;
  logic [XLEN-1:0] mag1, mag2, spec_val;

  always_comb begin
    is_div = func3_i[2];
    // MULH: both signed, MULHSU: rs1 only, DIV/REM: both signed
    sgn1 = is_div ? ~func3_i[0] : (func3_i[1] ^ func3_i[0]);
    sgn2 = is_div ? ~func3_i[0] : (func3_i[1:0] == 2'b01);
    s1   = sgn1 & reg1_i[XLEN-1];
    s2   = sgn2 & reg2_i[XLEN-1];
    mag1 = s1 ? (~reg1_i + 1'b1) : reg1_i;
    mag2 = s2 ? (~reg2_i + 1'b1) : reg2_i;
    div0 = is_div && (reg2_i == '0);
    ovf  = is_div && ~func3_i[0] && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&reg2_i);
    special = div0 | ovf;
    if (div0)
      spec_val = func3_i[1] ? reg1_i : '1;
    else
      spec_val = func3_i[1] ? '0 : reg1_i;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (valid_i && !flush_i) begin
        accept  = 1'b1;
        state_n = special ? DONE : CALC;
      end
      CALC: if (cnt == CW'(N - 1)) state_n = DONE;
      DONE: if (ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  // ---------------- one iteration of the datapath ----------------
  logic [2*XLEN-1:0] acc_n, mc_n;
  logic [XLEN-1:0]   xm_n, q, q_n, rem_n;
  logic [XLEN:0]     r;

  always_comb begin
    acc_n = acc;
    for (int j = 0; j < BPC; j++)
      if (x[j]) acc_n = acc_n + (mc << j);
    mc_n = mc << BPC;
    xm_n = x >> BPC;

    // restoring division: r needs one extra bit to hold the shifted remainder
    r = {1'b0, rem};
    q = x;
    for (int j = 0; j < BPC; j++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, y}) begin
        r    = r - {1'b0, y};
        q[0] = 1'b1;
      end
    end
    rem_n = r[XLEN-1:0];
    q_n   = q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op     <= '0;
      wd_r   <= '0;
      wreg_r <= 1'b0;
      neg_a  <= 1'b0;
      neg_r  <= 1'b0;
      spec   <= 1'b0;
      res    <= '0;
      x      <= '0;
      y      <= '0;
      rem    <= '0;
      mc     <= '0;
      acc    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op     <= func3_i;
      wd_r   <= wd_i;
      wreg_r <= wreg_i;
      neg_a  <= s1 ^ s2;
      neg_r  <= s1;
      spec   <= special;
      res    <= spec_val;
      x      <= is_div ? mag1 : mag2;
      y      <= mag2;
      rem    <= '0;
      mc     <= {{XLEN{1'b0}}, mag1};
      acc    <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (op[2]) begin
        x   <= q_n;
        rem <= rem_n;
      end else begin
        x   <= xm_n;
        mc  <= mc_n;
        acc <= acc_n;
      end
    end
  end

  // ---------------- result selection with sign correction ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, result;

  always_comb begin
    prod = neg_a ? (~acc + 1'b1) : acc;
    quo  = neg_a ? (~x + 1'b1) : x;
    rmd  = neg_r ? (~rem + 1'b1) : rem;
    if (spec)
      result = res;
    else if (op[2])
      result = op[1] ? rmd : quo;
    else if (op[1:0] == 2'b00)
      result = prod[XLEN-1:0];
    else
      result = prod[2*XLEN-1:XLEN];
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign valid_o = (state == DONE);
  assign wdata_o = valid_o ? result : '0;
  assign wd_o    = valid_o ? wd_r : '0;
  assign wreg_o  = valid_o & wreg_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv at BPC=1 and BPC=4
module tb_ex_muldiv;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_i, flush_i, ready_i, wreg_i;
  logic [2:0]  func3_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;

  logic        ready1, valid1, wreg1, busy1;
  logic [31:0] wdata1;
  logic [4:0]  wd1;
  logic        ready4, valid4, wreg4, busy4;
  logic [31:0] wdata4;
  logic [4:0]  wd4;

  ex_muldiv #(.XLEN(32), .BPC(1), .REGADDR(5)) dut1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready1), .func3_i(func3_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
    .valid_o(valid1), .ready_i(ready_i), .wdata_o(wdata1), .wd_o(wd1), .wreg_o(wreg1),
    .busy_o(busy1));

  ex_muldiv #(.XLEN(32), .BPC(4), .REGADDR(5)) dut4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready4), .func3_i(func3_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
    .valid_o(valid4), .ready_i(ready_i), .wdata_o(wdata4), .wd_o(wd4), .wreg_o(wreg4),
    .busy_o(busy4));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Expectations shared with the compare process.
  logic        ev1 = 1'b0, ev4 = 1'b0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_wd = '0;
  logic        exp_wreg = 1'b0;

  // Compare process: every cycle, each unit's outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (!ev1) check("dut1 valid_o unexpected", {31'b0, valid1}, 32'd0);
      if (!ev4) check("dut4 valid_o unexpected", {31'b0, valid4}, 32'd0);
      if (valid1 && ev1) begin
        check("dut1 wdata_o", wdata1, exp_data);
        check("dut1 wd_o", {27'b0, wd1}, {27'b0, exp_wd});
        check("dut1 wreg_o", {31'b0, wreg1}, {31'b0, exp_wreg});
      end
      if (valid4 && ev4) begin
        check("dut4 wdata_o", wdata4, exp_data);
        check("dut4 wd_o", {27'b0, wd4}, {27'b0, exp_wd});
        check("dut4 wreg_o", {31'b0, wreg4}, {31'b0, exp_wreg});
      end
      if (!valid1) check("dut1 wreg_o idle", {31'b0, wreg1}, 32'd0);
      if (!valid4) check("dut4 wreg_o idle", {31'b0, wreg4}, 32'd0);
    end
  end

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lit;
    logic        sp;
  } vec_t;

  vec_t vecs [12];

  task automatic wait_idle();
    for (int i = 0; i < 60 && !(ready1 && ready4); i++) @(negedge clk);
    check("both units idle before issue", {30'b0, ready1, ready4}, 32'd3);
  endtask

  // Issue one operation to both units, measure latency, check the literal result.
  task automatic do_op(input vec_t v, input logic [4:0] d, input logic wr, input logic hold);
    int lat1, lat4;
    logic [31:0] res1, res4;
    lat1 = 0; lat4 = 0; res1 = '0; res4 = '0;
    wait_idle();
    exp_data = model(v.f, v.a, v.b);
    exp_wd   = d;
    exp_wreg = wr;
    ev1 = 1'b1; ev4 = 1'b1;
    ready_i = ~hold;
    func3_i = v.f; reg1_i = v.a; reg2_i = v.b; wd_i = d; wreg_i = wr;
    valid_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40 && (lat1 == 0 || lat4 == 0); k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      reg1_i = $urandom; reg2_i = $urandom; wd_i = 5'($urandom);
      if (valid1 && lat1 == 0) begin lat1 = k; res1 = wdata1; end
      if (valid4 && lat4 == 0) begin lat4 = k; res4 = wdata4; end
    end
    check("dut1 latency", lat1, v.sp ? 32'd1 : 32'd33);
    check("dut4 latency", lat4, v.sp ? 32'd1 : 32'd9);
    check("dut1 literal result", res1, v.lit);
    check("dut4 literal result", res4, v.lit);
    if (hold) begin
      // Results must stay put; a new request must not be taken while in DONE.
      for (int k = 0; k < 5; k++) begin
        func3_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd3; valid_i = 1'b1;
        @(negedge clk);
        check("hold dut1 valid_o", {31'b0, valid1}, 32'd1);
        check("hold dut1 ready_o", {31'b0, ready1}, 32'd0);
        check("hold dut4 ready_o", {31'b0, ready4}, 32'd0);
        check("hold dut1 wdata_o", wdata1, v.lit);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(negedge clk);
    check("dut1 ready_o after consume", {31'b0, ready1}, 32'd1);
    check("dut4 busy_o after consume", {31'b0, busy4}, 32'd0);
    ev1 = 1'b0; ev4 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut1 ready/valid/busy/wreg"}, {28'b0, ready1, valid1, busy1, wreg1}, 32'h8);
    check({tag, " dut4 ready/valid/busy/wreg"}, {28'b0, ready4, valid4, busy4, wreg4}, 32'h8);
    check({tag, " dut1 wdata_o"}, wdata1, 32'd0);
    check({tag, " dut4 wdata_o"}, wdata4, 32'd0);
    check({tag, " dut1 wd_o"}, {27'b0, wd1}, 32'd0);
    check({tag, " dut4 wd_o"}, {27'b0, wd4}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; wreg_i = 1'b0;
    func3_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after reset");

    for (int i = 0; i < 12; i++)
      do_op(vecs[i], 5'(i + 1), i[0], 1'b0);

    // Result held in DONE while downstream stalls.
    do_op(vecs[6], 5'd21, 1'b1, 1'b1);

    // Flush dut1 at CALC iteration 10; dut4 has already finished by then.
    wait_idle();
    exp_data = model(3'd0, 32'd7, 32'hFFFF_FFFD); exp_wd = 5'd9; exp_wreg = 1'b1;
    ev1 = 1'b0; ev4 = 1'b1;
    func3_i = 3'd0; reg1_i = 32'd7; reg2_i = 32'hFFFF_FFFD; wd_i = 5'd9; wreg_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    check("dut1 busy at iteration 10", {31'b0, busy1}, 32'd1);
    flush_i = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush dut1 ready_o", {31'b0, ready1}, 32'd1);
    check("flush dut1 busy_o", {31'b0, busy1}, 32'd0);
    check("flush dut4 not accepted", {31'b0, busy4}, 32'd0);
    ev4 = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    func3_i = 3'd4; reg1_i = 32'hFFFF_FFF9; reg2_i = 32'd2; wd_i = 5'd3; wreg_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset dut1 busy", {31'b0, busy1}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("after abort dut1 ready_o", {31'b0, ready1}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
